// File: rtl/digit_argmax_classifier.sv
// Argmax stage behind the fully connected layer.
// On the first sampled edge of the FC done level (while armed), it latches the HEIGHT scores
// and scans them one class per cycle with a signed comparator. It then publishes the winning
// class, its score, and its margin over the runner-up.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   full_connected_layer_done  level flag, scores valid while high
//   output_layer               HEIGHT packed scores, class k at element HEIGHT-1-k
//   predict_num/score/margin   held result fields
//   predict_valid              result fields valid (held until next capture)
//   predict_pulse              one-cycle strobe when a new result lands
module digit_argmax_classifier #(
  parameter int unsigned BITS_INT = 4,
  parameter int unsigned BITS_FRC = 12,
  parameter int unsigned HEIGHT   = 10
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          full_connected_layer_done,
  input  logic [HEIGHT-1:0][BITS_INT+BITS_FRC-1:0]      output_layer,
  output logic [3:0]                                    predict_num,
  output logic [BITS_INT+BITS_FRC-1:0]                  predict_score,
  output logic [BITS_INT+BITS_FRC:0]                    predict_margin,
  output logic                                          predict_valid,
  output logic                                          predict_pulse
);

  localparam int unsigned W = BITS_INT + BITS_FRC;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

  state_t                   state_q, state_d;
  logic                     armed_q, armed_d;
  logic [HEIGHT-1:0][W-1:0] scores_q, scores_d;
  logic [W-1:0]             best_q, best_d;
  logic [W-1:0]             second_q, second_d;
  logic [3:0]               best_idx_q, best_idx_d;
  logic [3:0]               scan_idx_q, scan_idx_d;
  logic [3:0]               num_q, num_d;
  logic [W-1:0]             score_q, score_d;
  logic [W:0]               margin_q, margin_d;
  logic                     valid_q, valid_d;
  logic                     pulse_q, pulse_d;
  logic [W-1:0]             cand;

  // Next-state and datapath for capture, serial scan and result publication
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    scores_d   = scores_q;
    best_d     = best_q;
    second_d   = second_q;
    best_idx_d = best_idx_q;
    scan_idx_d = scan_idx_q;
    num_d      = num_q;
    score_d    = score_q;
    margin_d   = margin_q;
    valid_d    = valid_q;
    pulse_d    = 1'b0;
    cand       = scores_q[scan_idx_q];

    // Re-arm whenever done is seen low, including mid-scan
    if (!full_connected_layer_done) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (full_connected_layer_done && armed_q) begin
          // Reverse the bus order so slot k holds class k
          for (int k = 0; k < int'(HEIGHT); k++) scores_d[k] = output_layer[HEIGHT-1-k];
          best_d     = output_layer[HEIGHT-1];
          second_d   = MOST_NEG;
          best_idx_d = 4'd0;
          scan_idx_d = 4'd1;
          valid_d    = 1'b0;
          armed_d    = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        // Strict compare keeps the lower index on ties; an equal score can still become second
        if ($signed(cand) > $signed(best_q)) begin
          second_d   = best_q;
          best_d     = cand;
          best_idx_d = scan_idx_q;
        end else if ($signed(cand) > $signed(second_q)) begin
          second_d = cand;
        end
        scan_idx_d = scan_idx_q + 4'd1;
        if (scan_idx_q == 4'(HEIGHT-1)) state_d = RESULT;
      end
      RESULT: begin
        num_d    = best_idx_q;
        score_d  = best_q;
        margin_d = {best_q[W-1], best_q} - {second_q[W-1], second_q};
        valid_d  = 1'b1;
        pulse_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      armed_q    <= 1'b1;
      scores_q   <= '0;
      best_q     <= '0;
      second_q   <= '0;
      best_idx_q <= '0;
      scan_idx_q <= '0;
      num_q      <= '0;
      score_q    <= '0;
      margin_q   <= '0;
      valid_q    <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      scores_q   <= scores_d;
      best_q     <= best_d;
      second_q   <= second_d;
      best_idx_q <= best_idx_d;
      scan_idx_q <= scan_idx_d;
      num_q      <= num_d;
      score_q    <= score_d;
      margin_q   <= margin_d;
      valid_q    <= valid_d;
      pulse_q    <= pulse_d;
    end
  end

  assign predict_num    = num_q;
  assign predict_score  = score_q;
  assign predict_margin = margin_q;
  assign predict_valid  = valid_q;
  assign predict_pulse  = pulse_q;

endmodule

// File: tb/tb_digit_argmax_classifier.sv
// Directed bench for digit_argmax_classifier: a table of score vectors with hand-computed
// winners, plus sequences for the held-done, re-trigger, mid-scan change and mid-scan reset cases.
module tb_digit_argmax_classifier;

  localparam int unsigned W = 16;
  localparam int unsigned H = 10;

  typedef struct {
    logic [W-1:0] cls [H];
    logic [3:0]   num;
    logic [W-1:0] score;
    logic [W:0]   margin;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    done = 1'b0;
  logic [H-1:0][W-1:0]     output_layer = '0;
  logic [3:0]              predict_num;
  logic [W-1:0]            predict_score;
  logic [W:0]              predict_margin;
  logic                    predict_valid;
  logic                    predict_pulse;

  int tests = 0;
  int fails = 0;

  digit_argmax_classifier dut (
    .clk                       (clk),
    .reset                     (reset),
    .full_connected_layer_done (done),
    .output_layer              (output_layer),
    .predict_num               (predict_num),
    .predict_score             (predict_score),
    .predict_margin            (predict_margin),
    .predict_valid             (predict_valid),
    .predict_pulse             (predict_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    for (int k = 0; k < int'(H); k++) output_layer[H-1-k] = v.cls[k];
  endtask

  // Start a classification, wait (bounded) for the pulse, check latency and result fields
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit got;
    @(posedge clk); #1;
    drive(v);
    done = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (predict_pulse) got = 1'b1;
      else lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd10);
    chk({tag, " num"}, 32'(predict_num), 32'(v.num));
    chk({tag, " score"}, 32'(predict_score), 32'(v.score));
    chk({tag, " margin"}, 32'(predict_margin), 32'(v.margin));
    chk({tag, " valid"}, 32'(predict_valid), 32'd1);
    @(posedge clk); #1;
    chk({tag, " pulse one cycle"}, 32'(predict_pulse), 32'd0);
    chk({tag, " valid held"}, 32'(predict_valid), 32'd1);
    done = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vecs [7];
  vec_t va, vb;

  initial begin
    int pulses;
    int bad;

    // Vector table
    for (int k = 0; k < int'(H); k++) vecs[0].cls[k] = 16'h1000;
    vecs[0].cls[3] = 16'h2000;
    vecs[0].num = 4'd3; vecs[0].score = 16'h2000; vecs[0].margin = 17'h01000;

    for (int k = 0; k < int'(H); k++) vecs[1].cls[k] = 16'hF000;
    vecs[1].num = 4'd0; vecs[1].score = 16'hF000; vecs[1].margin = 17'h00000;

    for (int k = 0; k < int'(H); k++) vecs[2].cls[k] = 16'h0000;
    vecs[2].cls[9] = 16'h7FFF; vecs[2].cls[8] = 16'h8000;
    vecs[2].num = 4'd9; vecs[2].score = 16'h7FFF; vecs[2].margin = 17'h07FFF;

    for (int k = 0; k < int'(H); k++) vecs[3].cls[k] = 16'h8000;
    vecs[3].cls[0] = 16'h0500; vecs[3].cls[1] = 16'h0400;
    vecs[3].num = 4'd0; vecs[3].score = 16'h0500; vecs[3].margin = 17'h00100;

    for (int k = 0; k < int'(H); k++) vecs[4].cls[k] = 16'h0000;
    vecs[4].cls[2] = 16'h0300; vecs[4].cls[7] = 16'h0300;
    vecs[4].num = 4'd2; vecs[4].score = 16'h0300; vecs[4].margin = 17'h00000;

    for (int k = 0; k < int'(H); k++) vecs[5].cls[k] = 16'h8000;
    vecs[5].cls[6] = 16'h8001;
    vecs[5].num = 4'd6; vecs[5].score = 16'h8001; vecs[5].margin = 17'h00001;

    for (int k = 0; k < int'(H); k++) vecs[6].cls[k] = 16'h8000;
    vecs[6].cls[4] = 16'h7FFF;
    vecs[6].num = 4'd4; vecs[6].score = 16'h7FFF; vecs[6].margin = 17'h0FFFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset num", 32'(predict_num), 32'd0);
    chk("reset score", 32'(predict_score), 32'd0);
    chk("reset margin", 32'(predict_margin), 32'd0);
    chk("reset valid", 32'(predict_valid), 32'd0);
    chk("reset pulse", 32'(predict_pulse), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Done held high for 50 cycles yields exactly one pulse
    @(posedge clk); #1;
    drive(vecs[0]);
    done = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (predict_pulse) pulses++;
    end
    chk("held done pulses", 32'(pulses), 32'd1);
    chk("held done num", 32'(predict_num), 32'd3);
    done = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < int'(H); k++) va.cls[k] = 16'h0000;
    va.cls[5] = 16'h1000;
    drive(va);
    done = 1'b1;
    @(posedge clk); #1;  // E0
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (predict_valid !== 1'b0 || predict_pulse !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    if (predict_valid !== 1'b0 || predict_pulse !== 1'b0) bad++;
    chk("retrigger valid low during scan", 32'(bad), 32'd0);
    chk("retrigger old num kept", 32'(predict_num), 32'd3);
    @(posedge clk); #1;  // E10
    chk("retrigger pulse", 32'(predict_pulse), 32'd1);
    chk("retrigger num", 32'(predict_num), 32'd5);
    chk("retrigger margin", 32'(predict_margin), 32'h1000);
    done = 1'b0;
    @(posedge clk); #1;

    // Done drops at E4 and the bus changes mid-scan: latched scores win
    for (int k = 0; k < int'(H); k++) va.cls[k] = 16'h0000;
    va.cls[1] = 16'h3000;
    for (int k = 0; k < int'(H); k++) vb.cls[k] = 16'h0000;
    vb.cls[8] = 16'h7000;
    drive(va);
    done = 1'b1;
    repeat (4) @(posedge clk);  // E0..E3
    #1;
    done = 1'b0;
    drive(vb);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (predict_pulse) pulses++;
      if (predict_pulse) begin
        chk("midscan num", 32'(predict_num), 32'd1);
        chk("midscan score", 32'(predict_score), 32'h3000);
        chk("midscan margin", 32'(predict_margin), 32'h3000);
      end
    end
    chk("midscan pulses", 32'(pulses), 32'd1);

    // Reset at E5 aborts the scan
    @(posedge clk); #1;
    drive(vecs[2]);
    done = 1'b1;
    repeat (5) @(posedge clk);  // E0..E4
    #1;
    reset = 1'b0;
    @(posedge clk); #1;         // E5 samples reset
    chk("abort num", 32'(predict_num), 32'd0);
    chk("abort score", 32'(predict_score), 32'd0);
    chk("abort margin", 32'(predict_margin), 32'd0);
    chk("abort valid", 32'(predict_valid), 32'd0);
    done = 1'b0;
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (predict_pulse) pulses++;
    end
    chk("abort no pulse", 32'(pulses), 32'd0);
    run_vec(vecs[6], "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
